maxnet_ctrl: RTL and testbench
==============================

MAXNET_CTRL -- requirements
Module: maxnet_ctrl

Interface
REQ-001 The block SHALL have parameter PU_LAT, default 2, giving the cycles from an x-register write until the processing-unit outputs are valid; legal range 1..15.
REQ-002 The block SHALL have parameter MAX_ITER, default 20, giving the maximum number of update iterations before timeout; legal range 1..31.
REQ-003 Port clk  in  1: single clock; all state changes on the rising edge.
REQ-004 Port rst  in  1: asynchronous, active-low reset.
REQ-005 Port start  in  1: request to run one competition; sampled only in IDLE.
REQ-006 Port zer  in  1: datapath termination flag (enough x values have reached zero).
REQ-007 Port dp_out  in  5: datapath winner value (initial value of the surviving input).
REQ-008 Port sel  out  1: datapath mux select; 0 selects external inputs and loads the initial-value registers, 1 selects processing-unit feedback.
REQ-009 Port wen  out  1: datapath x-register write enable.
REQ-010 Port wene  out  1: datapath epsilon-register write enable.
REQ-011 Port busy  out  1: high in every state except IDLE.
REQ-012 Port done  out  1: one-cycle pulse marking the end of a competition.
REQ-013 Port timeout  out  1: set when the competition ended through MAX_ITER rather than zer; held until the next LOAD.
REQ-014 Port result  out  5: dp_out captured at the end of the competition; held until the next LOAD.
REQ-015 Port iter_cnt  out  5: number of UPDATE cycles executed in the current or last competition.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, WAIT, CHECK, UPDATE and DONE.
REQ-017 IDLE: sel=1, wen=0, wene=0; start=1 moves to LOAD; otherwise the FSM stays in IDLE.
REQ-018 LOAD (1 cycle): sel=0, wen=1, wene=1; iter_cnt, timeout and result clear to 0; wait counter loads PU_LAT; next state is WAIT.
REQ-019 WAIT (exactly PU_LAT cycles): sel=1, wen=0, wene=0; the wait counter decrements each cycle; the FSM moves to CHECK on the cycle the counter reaches 1.
REQ-020 CHECK (1 cycle): sel=1, wen=0; if zer=1, result<=dp_out and the next state is DONE.
REQ-021 CHECK: if zer=0 and iter_cnt==MAX_ITER, timeout<=1, result<=dp_out and the next state is DONE.
REQ-022 CHECK: in all other cases the next state is UPDATE.
REQ-023 zer SHALL take priority over timeout when both conditions hold in the same CHECK cycle.
REQ-024 UPDATE (1 cycle): sel=1, wen=1, wene=0; iter_cnt increments by 1; wait counter loads PU_LAT; next state is WAIT.
REQ-025 DONE (1 cycle): done=1, sel=1, wen=0; next state is IDLE unconditionally; start is ignored in this cycle.
REQ-026 start SHALL be ignored in every state other than IDLE; no queuing.
REQ-027 zer and dp_out SHALL be sampled only in CHECK.
REQ-028 sel SHALL be 0 only in LOAD, so the datapath initial-value registers stay stable in all other states.
REQ-029 Latency: with start high in cycle 0 (IDLE) and zer already 1 after the load, DONE SHALL occur in cycle PU_LAT+3.
REQ-030 Each UPDATE iteration SHALL add PU_LAT+2 cycles to the latency.
REQ-031 iter_cnt SHALL never exceed MAX_ITER.
REQ-032 All outputs SHALL be registered or decoded from the state register only, with no combinational path from any input to any output.

Reset
REQ-033 While rst=0, the FSM SHALL be forced immediately to IDLE, regardless of clk.
REQ-034 Reset values SHALL be: sel=1, wen=0, wene=0, busy=0, done=0, timeout=0, result=0, iter_cnt=0, wait counter=0.
REQ-035 Reset asserted mid-competition SHALL abort it with no done pulse.
REQ-036 After reset release, the first start SHALL be accepted in the first IDLE cycle.

Verification
REQ-037 Immediate win: PU_LAT=2, zer=1 from the load, dp_out=5'd9, start pulsed in cycle 0 -> LOAD in cycle 1, CHECK in cycle 4, done in cycle 5, result=9, iter_cnt=0, timeout=0.
REQ-038 Three iterations: zer rises after the 3rd UPDATE, dp_out=5'd12 -> exactly 3 wen pulses with sel=1, done in cycle 5+3*4=17, result=12, iter_cnt=3, timeout=0.
REQ-039 Timeout: MAX_ITER=4, zer held 0 -> 4 UPDATEs, done once, timeout=1, iter_cnt=4, result equals dp_out at the final CHECK.
REQ-040 Start while busy: start held high for the entire run -> exactly one LOAD per competition; a new LOAD starts on the cycle after DONE+1 (IDLE) only.
REQ-041 Mid-run reset: rst pulled low during WAIT of iteration 2 -> outputs take reset values asynchronously, no done pulse; a subsequent start runs normally.
REQ-042 Simultaneous zer and timeout in CHECK with MAX_ITER=2 -> timeout=0, done=1, result=dp_out.

Source files
------------

// File: rtl/maxnet_ctrl_if.sv
// Handshake and datapath-control bundle between the MAXNET sequencer and its datapath.
// The controller uses the slave view; the datapath (or a bench) uses master.
interface maxnet_ctrl_if;
  logic       start;
  logic       zer;
  logic [4:0] dp_out;
  logic       sel;
  logic       wen;
  logic       wene;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [4:0] result;
  logic [4:0] iter_cnt;

  modport master (
    output start, zer, dp_out,
    input  sel, wen, wene, busy, done, timeout, result, iter_cnt
  );

  modport slave (
    input  start, zer, dp_out,
    output sel, wen, wene, busy, done, timeout, result, iter_cnt
  );
endinterface

// File: rtl/maxnet_ctrl.sv
// MAXNET winner-take-all sequencer: loads the x/epsilon registers, then iterates
// processing-unit updates until the datapath flags termination or MAX_ITER is reached.
//
// state  | meaning
// IDLE   | waiting for start, datapath held on feedback
// LOAD   | external inputs written into x/epsilon/initial-value registers
// WAIT   | PU_LAT-cycle settle of the processing units
// CHECK  | sample zer/dp_out, decide finish or iterate
// UPDATE | write processing-unit feedback into x registers
// DONE   | one-cycle completion pulse
module maxnet_ctrl #(
  parameter int PU_LAT   = 2,
  parameter int MAX_ITER = 20
) (
  input logic          clk,
  input logic          rst,
  maxnet_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_CHECK,
    ST_UPDATE,
    ST_DONE
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;

  // Outputs are assigned alongside each transition so they always reflect the
  // state being entered, keeping inputs off every output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      bus.sel      <= 1'b1;
      bus.wen      <= 1'b0;
      bus.wene     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.timeout  <= 1'b0;
      bus.result   <= 5'd0;
      bus.iter_cnt <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state        <= ST_LOAD;
            bus.sel      <= 1'b0;
            bus.wen      <= 1'b1;
            bus.wene     <= 1'b1;
            bus.busy     <= 1'b1;
            bus.iter_cnt <= 5'd0;
            bus.timeout  <= 1'b0;
            bus.result   <= 5'd0;
            wait_cnt     <= 4'(PU_LAT);
          end
        end

        ST_LOAD: begin
          state    <= ST_WAIT;
          bus.sel  <= 1'b1;
          bus.wen  <= 1'b0;
          bus.wene <= 1'b0;
        end

        ST_WAIT: begin
          if (wait_cnt <= 4'd1) begin
            state    <= ST_CHECK;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ST_CHECK: begin
          if (bus.zer) begin
            state      <= ST_DONE;
            bus.result <= bus.dp_out;
            bus.done   <= 1'b1;
          end else if (bus.iter_cnt == 5'(MAX_ITER)) begin
            state       <= ST_DONE;
            bus.result  <= bus.dp_out;
            bus.timeout <= 1'b1;
            bus.done    <= 1'b1;
          end else begin
            state   <= ST_UPDATE;
            bus.wen <= 1'b1;
          end
        end

        ST_UPDATE: begin
          state        <= ST_WAIT;
          bus.wen      <= 1'b0;
          bus.iter_cnt <= bus.iter_cnt + 5'd1;
          wait_cnt     <= 4'(PU_LAT);
        end

        ST_DONE: begin
          state    <= ST_IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= ST_IDLE;
          bus.sel  <= 1'b1;
          bus.wen  <= 1'b0;
          bus.wene <= 1'b0;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Randomized bench for maxnet_ctrl: a datapath stand-in raises zer after a chosen
// number of updates, and a latency/iteration model predicts each competition's outcome.
module tb_maxnet_ctrl;
  localparam int PU_LAT   = 2;
  localparam int MAX_ITER = 4;
  localparam int NEVER    = 99;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maxnet_ctrl_if bus ();

  maxnet_ctrl #(.PU_LAT(PU_LAT), .MAX_ITER(MAX_ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  logic [4:0] dp_hist [int];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_inputs(input int upd, input int k, input int dp_fixed);
    bus.zer    = (upd >= k);
    bus.dp_out = (dp_fixed >= 0) ? 5'(dp_fixed) : 5'($urandom);
    dp_hist[cyc] = bus.dp_out;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sel"},     int'(bus.sel),      1);
    chk({tag, "_wen"},     int'(bus.wen),      0);
    chk({tag, "_wene"},    int'(bus.wene),     0);
    chk({tag, "_busy"},    int'(bus.busy),     0);
    chk({tag, "_done"},    int'(bus.done),     0);
    chk({tag, "_timeout"}, int'(bus.timeout),  0);
    chk({tag, "_result"},  int'(bus.result),   0);
    chk({tag, "_iter"},    int'(bus.iter_cnt), 0);
  endtask

  // k: updates after which zer rises (NEVER = hold low); hold: keep start high;
  // abort_upd: pull reset during the WAIT following that many updates (-1 = none).
  task automatic run_comp(input int k, input bit hold, input int abort_upd, input int dp_fixed);
    int  t0, upd, loads, dcyc, exp_it, exp_lat, exp_res;
    bit  exp_to, fin;
    exp_it  = (k <= MAX_ITER) ? k : MAX_ITER;
    exp_to  = (k > MAX_ITER);
    exp_lat = PU_LAT + 3 + exp_it * (PU_LAT + 2);
    upd = 0; loads = 0; dcyc = 0; fin = 0;
    t0 = cyc;
    bus.start = 1'b1;
    drive_inputs(0, k, dp_fixed);
    for (int i = 0; i < 300 && !fin; i++) begin
      tick();
      if (!hold) bus.start = 1'b0;
      if (!bus.sel) begin
        loads++;
        chk("load_wen_wene", int'({bus.wen, bus.wene}), 3);
      end
      if (bus.wen && bus.sel) upd++;
      if (abort_upd >= 0 && upd == abort_upd && bus.busy && !bus.wen) begin
        rst = 1'b0;
        #1;
        check_reset_values("async_rst");
        for (int j = 0; j < 3; j++) begin
          tick();
          chk("no_done_in_reset", int'(bus.done), 0);
        end
        rst = 1'b1;
        return;
      end
      if (bus.done) begin
        fin  = 1;
        dcyc = cyc;
      end
      drive_inputs(upd, k, dp_fixed);
    end
    if (!fin) begin
      chk("done_within_budget", 0, 1);
      return;
    end
    exp_res = int'(dp_hist[dcyc - 1]);
    chk("latency",     dcyc - t0,             exp_lat);
    chk("result",      int'(bus.result),      exp_res);
    chk("iter_cnt",    int'(bus.iter_cnt),    exp_it);
    chk("timeout",     int'(bus.timeout),     int'(exp_to));
    chk("load_count",  loads,                 1);
    chk("update_wens", upd,                   exp_it);
    chk("busy_in_done", int'(bus.busy),       1);
    tick();
    chk("done_pulse_width", int'(bus.done),   0);
    chk("idle_busy",        int'(bus.busy),   0);
    chk("idle_sel",         int'(bus.sel),    1);
    chk("result_held",      int'(bus.result), exp_res);
    if (hold) begin
      tick();
      chk("relaunch_load", int'(bus.sel), 0);
      bus.start = 1'b0;
      bus.zer   = 1'b1;
      fin = 0;
      for (int i = 0; i < 100 && !fin; i++) begin
        tick();
        if (bus.done) fin = 1;
      end
      chk("relaunch_done", int'(fin), 1);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.zer    = 1'b0;
    bus.dp_out = 5'd0;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b1;

    run_comp(0, 1'b0, -1, 9);          // immediate win
    run_comp(3, 1'b0, -1, 12);         // three iterations
    run_comp(NEVER, 1'b0, -1, -1);     // timeout
    run_comp(MAX_ITER, 1'b0, -1, -1);  // zer and iteration limit coincide
    run_comp(2, 1'b1, -1, -1);         // start held for the whole run
    run_comp(NEVER, 1'b0, 2, -1);      // reset during WAIT of iteration 2
    run_comp(1, 1'b0, -1, -1);         // first start right after reset release

    for (int n = 0; n < 12; n++)
      run_comp(int'($urandom_range(0, MAX_ITER + 1)), 1'($urandom_range(0, 1)), -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
